// File: rtl/mircore_pkg.sv
// Shared definitions for the core's interrupt handling: interrupt codes and the
// sequencer state encoding.
package mircore_pkg;

  localparam int unsigned INTR_INPUT  = 1;
  localparam int unsigned INTR_OUTPUT = 2;
  localparam int unsigned INTR_END    = 3;

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StInWait  = 3'd1,
    StOutHold = 3'd2,
    StResume  = 3'd3,
    StHalt    = 3'd4
  } state_e;

endpackage

// File: rtl/intrpt_sequencer.sv
// Freezes the core around interrupt service: waits for user input, holds for the
// display time after an output, and halts permanently on program end.
module intrpt_sequencer
  import mircore_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned OUT_HOLD_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  intrpt,
  input  logic [DATA_WIDTH-1:0] intrpt_val,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] out_src,
  output logic                  stall,
  output logic                  in_req,
  output logic                  rf_wr_en,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_load,
  output logic                  halted,
  output logic [2:0]            state_dbg
);

  localparam int unsigned CntW = $clog2(OUT_HOLD_CYCLES) + 1;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic                    rf_wr_en_q;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q;
  logic [DATA_WIDTH-1:0]   disp_data_q;
  logic                    disp_load_q;

  logic code_in, code_out, code_end, code_valid;

  // Full-width compare: any nonzero upper bits make the code invalid.
  assign code_in    = (intrpt_val == DATA_WIDTH'(INTR_INPUT));
  assign code_out   = (intrpt_val == DATA_WIDTH'(INTR_OUTPUT));
  assign code_end   = (intrpt_val == DATA_WIDTH'(INTR_END));
  assign code_valid = code_in | code_out | code_end;

  always_comb begin
    stall = 1'b0;
    case (state_q)
      StRun:                      stall = intrpt & code_valid;
      StInWait, StOutHold, StHalt: stall = 1'b1;
      default:                    stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      disp_data_q  <= '0;
      disp_load_q  <= 1'b0;
    end else begin
      rf_wr_en_q  <= 1'b0;
      disp_load_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (intrpt) begin
            if (code_in) begin
              state_q <= StInWait;
            end else if (code_out) begin
              disp_data_q <= out_src;
              disp_load_q <= 1'b1;
              cnt_q       <= CntW'(OUT_HOLD_CYCLES - 1);
              state_q     <= StOutHold;
            end else if (code_end) begin
              state_q <= StHalt;
            end
          end
        end
        StInWait: begin
          if (in_valid) begin
            rf_wr_data_q <= in_data;
            rf_wr_en_q   <= 1'b1;
            state_q      <= StResume;
          end
        end
        StOutHold: begin
          if (cnt_q == '0) begin
            state_q <= StResume;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        // One cycle that ignores the still-asserted strobe of the serviced request.
        StResume: state_q <= StRun;
        StHalt:   state_q <= StHalt;
        default:  state_q <= StRun;
      endcase
    end
  end

  assign in_req     = (state_q == StInWait);
  assign halted     = (state_q == StHalt);
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_data = rf_wr_data_q;
  assign disp_data  = disp_data_q;
  assign disp_load  = disp_load_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_intrpt_sequencer.sv
// Bench for intrpt_sequencer: per-cycle expectation records queued at drive time
// and compared on the falling edge.
module tb_intrpt_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        intrpt;
  logic [31:0] intrpt_val;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] out_src;
  logic        stall, in_req, rf_wr_en, disp_load, halted;
  logic [31:0] rf_wr_data, disp_data;
  logic [2:0]  state_dbg;

  always #5 clock = ~clock;

  intrpt_sequencer #(
    .DATA_WIDTH      (32),
    .OUT_HOLD_CYCLES (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .intrpt     (intrpt),
    .intrpt_val (intrpt_val),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_src    (out_src),
    .stall      (stall),
    .in_req     (in_req),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_data (rf_wr_data),
    .disp_data  (disp_data),
    .disp_load  (disp_load),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  typedef struct packed {
    logic        rst;
    logic        intr;
    logic [31:0] code;
    logic        iv;
    logic [31:0] idata;
    logic [31:0] osrc;
    logic        e_stall;
    logic        e_inreq;
    logic        e_wren;
    logic [31:0] e_wdata;
    logic [31:0] e_disp;
    logic        e_dload;
    logic        e_halt;
    logic [2:0]  e_st;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic intr, input logic [31:0] code,
                              input logic iv, input logic [31:0] idata,
                              input logic [31:0] osrc, input logic e_stall,
                              input logic e_inreq, input logic e_wren,
                              input logic [31:0] e_wdata, input logic [31:0] e_disp,
                              input logic e_dload, input logic e_halt,
                              input logic [2:0] e_st);
    vec_t v;
    v.rst = rst; v.intr = intr; v.code = code; v.iv = iv; v.idata = idata; v.osrc = osrc;
    v.e_stall = e_stall; v.e_inreq = e_inreq; v.e_wren = e_wren; v.e_wdata = e_wdata;
    v.e_disp = e_disp; v.e_dload = e_dload; v.e_halt = e_halt; v.e_st = e_st;
    return v;
  endfunction

  vec_t exp_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  // Monitor: pops the expectation for the cycle whose inputs were just driven.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        vec_t e;
        e = exp_q.pop_front();
        chk("stall",      {31'd0, stall},      {31'd0, e.e_stall});
        chk("in_req",     {31'd0, in_req},     {31'd0, e.e_inreq});
        chk("rf_wr_en",   {31'd0, rf_wr_en},   {31'd0, e.e_wren});
        chk("rf_wr_data", rf_wr_data,          e.e_wdata);
        chk("disp_data",  disp_data,           e.e_disp);
        chk("disp_load",  {31'd0, disp_load},  {31'd0, e.e_dload});
        chk("halted",     {31'd0, halted},     {31'd0, e.e_halt});
        chk("state_dbg",  {29'd0, state_dbg},  {29'd0, e.e_st});
        cyc++;
      end
    end
  end

  task automatic step(input vec_t v);
    @(posedge clock);
    #1;
    reset      = v.rst;
    intrpt     = v.intr;
    intrpt_val = v.code;
    in_valid   = v.iv;
    in_data    = v.idata;
    out_src    = v.osrc;
    exp_q.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; intrpt = 1'b0; intrpt_val = '0; in_valid = 1'b0; in_data = '0;
    out_src = '0;
    repeat (2) @(posedge clock);

    // Idle after reset, with in_valid pulses in RUN that must not write.
    for (int i = 0; i < 10; i++) begin
      tbl.push_back(mk(0, 0, 0, (i == 3 || i == 4), 32'h55, 0,
                       0, 0, 0, 0, 0, 0, 0, 3'd0));
    end
    // Input request; strobe held high through RESUME.
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3'd1));
    end
    tbl.push_back(mk(0, 1, 1, 1, 32'hA5, 0, 1, 1, 0, 0, 0, 0, 0, 3'd1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'hA5, 0, 0, 0, 3'd3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA5, 0, 0, 0, 3'd0));
    // Output request; out_src changes during hold and must not be captured.
    tbl.push_back(mk(0, 1, 2, 0, 0, 32'h1234, 1, 0, 0, 32'hA5, 0, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 32'h9999, 1, 0, 0, 32'hA5, 32'h1234, 1, 0, 3'd2));
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(0, 1, 2, 0, 0, 32'h9999, 1, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd2));
    end
    tbl.push_back(mk(0, 1, 2, 0, 0, 32'h9999, 0, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd0));
    // Invalid codes are ignored.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 32'h8000_0001, 0, 0, 0, 0, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 32'h8000_0003, 0, 0, 0, 0, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Early in_valid in the detection cycle is dropped; reset mid IN_WAIT clears all.
    step(mk(0, 1, 1, 1, 32'h77, 0, 1, 0, 0, 32'hA5, 32'h1234, 0, 0, 3'd0));
    step(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 32'hA5, 32'h1234, 0, 0, 3'd1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));

    // Reset mid OUT_HOLD.
    step(mk(0, 1, 2, 0, 0, 32'hBEEF, 1, 0, 0, 0, 0, 0, 0, 3'd0));
    step(mk(0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 32'hBEEF, 1, 0, 3'd2));
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hBEEF, 0, 0, 3'd2));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));

    // Program end: permanent halt despite activity, cleared only by reset.
    step(mk(0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0));
    for (int i = 0; i < 50; i++) begin
      step(mk(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)), $urandom, $urandom,
              1, 0, 0, 0, 0, 0, 1, 3'd4));
    end
    step(mk(1, 1, 1, 1, 32'h1, 0, 1, 0, 0, 0, 0, 0, 1, 3'd4));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));

    @(negedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
